// File: rtl/trigger_event_tx_pkg.sv
// Shared definitions for the trigger transmit path.
//   - state_t      : FIRE/HOLD sequencer state encoding
//   - DEF_*        : default channel count, holdoff and overrun counter width
package trigger_event_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_N_EVT   = 8;
  localparam int DEF_HOLDOFF = 16;
  localparam int DEF_OVF_W   = 8;

endpackage

// File: rtl/trigger_event_tx_if.sv
// Host-facing signal bundle of the trigger transmitter.
//   event_in, enable_mask, ack_trig, clear_all, ovf_sel : host/system -> transmitter
//   ep_trigger, sticky, ovf_count, busy                 : transmitter -> host
// master = the side driving events and acknowledges, slave = the transmitter.
interface trigger_event_tx_if #(
  parameter int N_EVT = 8,
  parameter int OVF_W = 8
);
  logic [N_EVT-1:0] event_in;
  logic [N_EVT-1:0] enable_mask;
  logic [N_EVT-1:0] ack_trig;
  logic             clear_all;
  logic [4:0]       ovf_sel;
  logic [N_EVT-1:0] ep_trigger;
  logic [N_EVT-1:0] sticky;
  logic [OVF_W-1:0] ovf_count;
  logic             busy;

  modport master (
    output event_in, enable_mask, ack_trig, clear_all, ovf_sel,
    input  ep_trigger, sticky, ovf_count, busy
  );

  modport slave (
    input  event_in, enable_mask, ack_trig, clear_all, ovf_sel,
    output ep_trigger, sticky, ovf_count, busy
  );
endinterface

// File: rtl/trigger_event_tx_sat_counter.sv
// Saturating up-counter with synchronous clear; one per event channel.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   clr   : synchronous clear, dominates inc
//   inc   : increment request (ignored once all-ones is reached)
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counter register: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/trigger_event_tx.sv
// Transmit side of the trigger path. Rising edges on enabled event channels
// are collected into a pending set and sent as one-cycle trigger words, at
// most one word every HOLDOFF+1 cycles. Sent bits stay visible in sticky
// until the host acknowledges them; edges arriving while a channel is
// already pending or unacknowledged are counted as overruns instead.
//   sys_clk / reset : clock, asynchronous active-high reset
//   bus (slave)     : event_in, enable_mask, ack_trig, clear_all, ovf_sel in;
//                     ep_trigger, sticky, ovf_count, busy out (all registered)
module trigger_event_tx
  import trigger_event_tx_pkg::*;
#(
  parameter int N_EVT   = DEF_N_EVT,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int OVF_W   = DEF_OVF_W
) (
  input logic               sys_clk,
  input logic               reset,
  trigger_event_tx_if.slave bus
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  state_t             state, state_next;
  logic [N_EVT-1:0]   prev;
  logic [N_EVT-1:0]   pending, pending_next;
  logic [N_EVT-1:0]   sticky_bits, sticky_next;
  logic [N_EVT-1:0]   word, word_next;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_next;
  logic               busy_reg, busy_next;
  logic [OVF_W-1:0]   ovf_count_reg, ovf_mux;
  logic [OVF_W-1:0]   ovf [N_EVT];

  logic [N_EVT-1:0]   rise, overrun, fresh;
  logic               launch;

  // An edge on a channel that is still pending or unacknowledged is an
  // overrun; only edges on free channels join the pending set.
  assign rise    = bus.event_in & ~prev & bus.enable_mask;
  assign overrun = rise & (pending | sticky_bits);
  assign fresh   = rise & ~pending & ~sticky_bits;

  // A word leaves when something is pending and the holdoff has expired;
  // the last HOLD cycle may launch directly so spacing is exactly HOLDOFF+1.
  assign launch = (pending != {N_EVT{1'b0}}) &&
                  ((state == ST_IDLE) ||
                   ((state == ST_HOLD) && (hold_cnt == {CNT_W{1'b0}})));

  // Next-state and datapath decode for the fire/holdoff sequencer.
  always_comb begin
    state_next    = state;
    pending_next  = pending | fresh;
    // The bits of the word on the wire are re-asserted during FIRE so an
    // acknowledge landing on that cycle cannot clear them.
    sticky_next   = (sticky_bits & ~bus.ack_trig) |
                    ((state == ST_FIRE) ? word : {N_EVT{1'b0}});
    word_next     = {N_EVT{1'b0}};
    hold_cnt_next = hold_cnt;

    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_FIRE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FIRE: begin
        state_next    = ST_HOLD;
        hold_cnt_next = HOLD_LOAD;
      end
      ST_HOLD: begin
        if (hold_cnt == {CNT_W{1'b0}}) begin
          if (launch) begin
            state_next = ST_FIRE;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Launch: the whole pending set becomes the word; only this cycle's
    // fresh edges remain pending.
    if (launch) begin
      word_next    = pending;
      sticky_next  = sticky_next | pending;
      pending_next = fresh;
    end else begin
      word_next = {N_EVT{1'b0}};
    end

    if (bus.clear_all) begin
      state_next    = ST_IDLE;
      pending_next  = {N_EVT{1'b0}};
      sticky_next   = {N_EVT{1'b0}};
      word_next     = {N_EVT{1'b0}};
      hold_cnt_next = {CNT_W{1'b0}};
    end else begin
      state_next = state_next;
    end

    busy_next = (state_next == ST_HOLD);
  end

  // Sequencer and datapath registers; edge history follows event_in always.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev        <= {N_EVT{1'b0}};
      pending     <= {N_EVT{1'b0}};
      sticky_bits <= {N_EVT{1'b0}};
      word        <= {N_EVT{1'b0}};
      hold_cnt    <= {CNT_W{1'b0}};
      busy_reg    <= 1'b0;
    end else begin
      state       <= state_next;
      prev        <= bus.event_in;
      pending     <= pending_next;
      sticky_bits <= sticky_next;
      word        <= word_next;
      hold_cnt    <= hold_cnt_next;
      busy_reg    <= busy_next;
    end
  end

  // Per-channel saturating overrun counters.
  for (genvar i = 0; i < N_EVT; i++) begin : g_ovf
    sat_counter #(.W(OVF_W)) u_cnt (
      .clk   (sys_clk),
      .rst   (reset),
      .clr   (bus.clear_all),
      .inc   (overrun[i]),
      .count (ovf[i])
    );
  end

  // Overrun read select; out-of-range indices read zero.
  always_comb begin
    ovf_mux = {OVF_W{1'b0}};
    for (int i = 0; i < N_EVT; i++) begin
      if (bus.ovf_sel == 5'(i)) begin
        ovf_mux = ovf[i];
      end else begin
        ovf_mux = ovf_mux;
      end
    end
  end

  // Registered overrun read port.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ovf_count_reg <= {OVF_W{1'b0}};
    end else if (bus.clear_all) begin
      ovf_count_reg <= {OVF_W{1'b0}};
    end else begin
      ovf_count_reg <= ovf_mux;
    end
  end

  assign bus.ep_trigger = word;
  assign bus.sticky     = sticky_bits;
  assign bus.busy       = busy_reg;
  assign bus.ovf_count  = ovf_count_reg;

endmodule

// File: tb/tb_trigger_event_tx.sv
// Bench for trigger_event_tx: directed scenarios followed by random traffic,
// all compared each cycle with a transaction-level model built from the
// externally visible rules (edge -> pending -> word, holdoff timing,
// sticky/ack, overrun counting).
module tb_trigger_event_tx;
  localparam int N    = 8;
  localparam int HO   = 16;
  localparam int W    = 8;
  localparam int OMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_event_tx_if #(.N_EVT(N), .OVF_W(W)) bus ();

  trigger_event_tx #(.N_EVT(N), .HOLDOFF(HO), .OVF_W(W)) dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int words = 0;

  // reference model state
  logic [N-1:0] m_prev, m_pend, m_sticky, m_ep;
  logic         m_busy;
  int           m_ovf_count;
  int           m_ovf [N];
  int           m_cyc;
  int           m_last;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_sticky = '0; m_ep = '0;
    m_busy = 1'b0; m_ovf_count = 0; m_last = -1000;
    for (int i = 0; i < N; i++) m_ovf[i] = 0;
  endtask

  // One clock edge of the model, using the inputs held during the cycle.
  task automatic model_step();
    logic [N-1:0] rise, ovr, fresh, n_pend, n_sticky, n_ep;
    logic fire;
    int sel_val;
    if (rst) begin
      model_reset();
    end else if (bus.clear_all) begin
      m_prev = bus.event_in;
      m_pend = '0; m_sticky = '0; m_ep = '0; m_busy = 1'b0;
      m_ovf_count = 0; m_last = -1000;
      for (int i = 0; i < N; i++) m_ovf[i] = 0;
    end else begin
      rise  = bus.event_in & ~m_prev & bus.enable_mask;
      ovr   = rise & (m_pend | m_sticky);
      fresh = rise & ~m_pend & ~m_sticky;
      fire  = (m_pend != '0) && (m_cyc + 1 >= m_last + HO + 1);
      n_sticky = (m_sticky & ~bus.ack_trig) | m_ep;
      if (fire) begin
        n_ep = m_pend; n_sticky = n_sticky | m_pend; n_pend = fresh;
        m_last = m_cyc + 1;
      end else begin
        n_ep = '0; n_pend = m_pend | fresh;
      end
      m_busy = !fire && (m_cyc + 1 > m_last) && (m_cyc + 1 <= m_last + HO);
      sel_val = 0;
      for (int i = 0; i < N; i++) if (bus.ovf_sel == 5'(i)) sel_val = m_ovf[i];
      m_ovf_count = sel_val;
      for (int i = 0; i < N; i++)
        if (ovr[i] && m_ovf[i] < OMAX) m_ovf[i] = m_ovf[i] + 1;
      m_ep = n_ep; m_pend = n_pend; m_sticky = n_sticky;
      m_prev = bus.event_in;
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    if (bus.ep_trigger != '0) words++;
    check("ep_trigger", 32'(bus.ep_trigger), 32'(m_ep));
    check("sticky",     32'(bus.sticky),     32'(m_sticky));
    check("busy",       32'(bus.busy),       32'(m_busy));
    check("ovf_count",  32'(bus.ovf_count),  32'(m_ovf_count));
  endtask

  initial begin
    m_cyc = 0;
    rst = 1'b1;
    bus.event_in = '0; bus.enable_mask = '0; bus.ack_trig = '0;
    bus.clear_all = 1'b0; bus.ovf_sel = 5'd0;
    model_reset();
    tick(); tick();
    check("reset_ep", 32'(bus.ep_trigger), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();

    // single event on channel 3, then acknowledge
    bus.enable_mask = 8'hFF;
    bus.event_in = 8'h08;
    tick(); tick();
    check("single_word", 32'(bus.ep_trigger), 32'h08);
    tick();
    check("single_sticky", 32'(bus.sticky), 32'h08);
    check("single_one_cycle", 32'(bus.ep_trigger), 32'h0);
    bus.ack_trig = 8'h08; tick(); bus.ack_trig = 8'h00;
    check("single_ack", 32'(bus.sticky), 32'h0);
    bus.event_in = 8'h00;
    repeat (20) tick();

    // holdoff spacing: ch0 at t, ch1 at t+4
    bus.event_in = 8'h01;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 2)       check("holdoff_w1", 32'(bus.ep_trigger), 32'h01);
      else if (k == 19) check("holdoff_w2", 32'(bus.ep_trigger), 32'h02);
      else              check("holdoff_gap", 32'(bus.ep_trigger), 32'h0);
      if (k == 4) bus.event_in = 8'h03;
    end
    bus.ack_trig = 8'hFF; tick(); bus.ack_trig = 8'h00;
    bus.event_in = 8'h00;
    repeat (20) tick();

    // overrun saturation on ch2
    words = 0;
    for (int k = 0; k < 300; k++) begin
      bus.event_in[2] = 1'b1; tick();
      bus.event_in[2] = 1'b0; tick();
    end
    check("ovr_words", 32'(words), 32'd1);
    check("ovr_sticky", 32'(bus.sticky), 32'h04);
    bus.ovf_sel = 5'd2; tick();
    check("ovr_sat", 32'(bus.ovf_count), 32'hFF);
    bus.clear_all = 1'b1; tick(); bus.clear_all = 1'b0; tick();
    check("ovr_clear_cnt", 32'(bus.ovf_count), 32'h0);
    check("ovr_clear_sticky", 32'(bus.sticky), 32'h0);
    repeat (20) tick();

    // ack colliding with FIRE of bit0
    bus.event_in = 8'h01;
    tick(); tick();
    check("race_word", 32'(bus.ep_trigger), 32'h01);
    bus.ack_trig = 8'h01; tick(); bus.ack_trig = 8'h00;
    check("race_ack_sticky", 32'(bus.sticky[0]), 32'h1);
    bus.ack_trig = 8'h01; tick(); bus.ack_trig = 8'h00;
    bus.event_in = 8'h00;
    repeat (20) tick();

    // clear_all coincident with a rise
    words = 0;
    bus.event_in = 8'h10; bus.clear_all = 1'b1; tick(); bus.clear_all = 1'b0;
    repeat (20) tick();
    check("race_clear_words", 32'(words), 32'd0);
    bus.event_in = 8'h00; tick();

    // enabling a channel whose level is already high gives no edge
    bus.enable_mask = 8'hDF; bus.event_in = 8'h20;
    repeat (3) tick();
    words = 0;
    bus.enable_mask = 8'hFF;
    repeat (5) tick();
    check("mask_no_word", 32'(words), 32'd0);
    bus.event_in = 8'h00; tick();
    bus.event_in = 8'h20; tick(); tick();
    check("mask_word", 32'(bus.ep_trigger), 32'h20);
    bus.event_in = 8'h00;
    bus.ack_trig = 8'hFF; tick(); bus.ack_trig = 8'h00;
    repeat (20) tick();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bus.event_in = bus.event_in ^ (8'($urandom()) & 8'($urandom()));
      if ($urandom_range(0, 49) == 0) bus.enable_mask = 8'($urandom());
      bus.ack_trig  = ($urandom_range(0, 5) == 0) ? 8'($urandom()) : 8'h00;
      bus.clear_all = ($urandom_range(0, 299) == 0);
      bus.ovf_sel   = 5'($urandom_range(0, 31));
      tick();
    end
    bus.clear_all = 1'b1; bus.ack_trig = 8'h00; bus.event_in = 8'h00;
    tick();
    bus.clear_all = 1'b0; bus.enable_mask = 8'hFF;
    tick();

    // async reset mid-HOLD with pending = 8'h05
    bus.event_in = 8'h40;
    tick(); tick(); tick();
    bus.event_in = 8'h45;
    tick(); tick();
    check("rst_busy_before", 32'(bus.busy), 32'h1);
    check("rst_sticky_before", 32'(bus.sticky), 32'h40);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_ep", 32'(bus.ep_trigger), 32'h0);
    check("rst_async_sticky", 32'(bus.sticky), 32'h0);
    check("rst_async_busy", 32'(bus.busy), 32'h0);
    check("rst_async_ovf", 32'(bus.ovf_count), 32'h0);
    bus.event_in = 8'h00;
    tick();
    rst = 1'b0;
    words = 0;
    repeat (20) tick();
    check("rst_no_word", 32'(words), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
